spio_hss_multiplexer_rx_pkt_store: RTL

SPIO_HSS_MULTIPLEXER_RX_PKT_STORE -- requirements
Module: spio_hss_multiplexer_rx_pkt_store

---
 rtl/spio_hss_multiplexer_rx_pkt_store.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spio_hss_multiplexer_rx_pkt_store.sv
// Receive packet store for the HSS multiplexer: sequence-checks incoming slots,
// buffers in-order packets for the router, and raises ack/nak and local flow control.
module spio_hss_multiplexer_rx_pkt_store #(
  parameter int SEQ_BITS = 7,
  parameter int PKT_BITS = 72,
  parameter int BUF_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_vld,
  input  logic                rx_err,
  input  logic [SEQ_BITS-1:0] rx_seq,
  input  logic                rx_pres,
  input  logic [PKT_BITS-1:0] rx_data,
  output logic [PKT_BITS-1:0] pkt_data,
  output logic                pkt_vld,
  input  logic                pkt_rdy,
  output logic                ack_vld,
  output logic                ack_nak,
  output logic [SEQ_BITS-1:0] ack_seq,
  input  logic                ack_rdy,
  output logic                cfc_loc,
  output logic                empty,
  output logic                full,
  output logic                dbg_ack_state
);

  localparam int BUF_LEN = 1 << BUF_BITS;
  localparam logic [BUF_BITS:0] BUF_LEN_P = (BUF_BITS + 1)'(BUF_LEN);
  localparam logic [BUF_BITS:0] CFC_LIMIT = (BUF_BITS + 1)'(BUF_LEN - 3);

  typedef enum logic {
    ACK_IDLE  = 1'b0,
    ACK_OFFER = 1'b1
  } ack_state_t;

  ack_state_t          state, state_nxt;
  logic [SEQ_BITS-1:0] exp_seq, exp_seq_nxt;
  logic                accept, reject, push, pop, nak_set;
  logic                nak_sent, nak_pend, ack_pend;
  logic                nak_eff, ack_eff, load;
  logic [BUF_BITS:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, occ_nxt;
  logic [PKT_BITS-1:0] mem [BUF_LEN];

  // Handshakes: pkt_vld/pkt_rdy and ack_vld/ack_rdy transfer on a clock edge where
  // both are high; once raised, a valid and its payload hold until that edge.
  // The link side has no back-pressure: a slot that cannot be taken is dropped.
  always_comb begin
    accept      = rx_vld && !rx_err && (rx_seq == exp_seq) && (!rx_pres || !full);
    reject      = rx_vld && !accept;
    push        = accept && rx_pres;
    pop         = pkt_vld && pkt_rdy;
    nak_set     = reject && !nak_sent;
    exp_seq_nxt = accept ? exp_seq + SEQ_BITS'(1) : exp_seq;
    wr_ptr_nxt  = wr_ptr + (BUF_BITS + 1)'(push);
    rd_ptr_nxt  = rd_ptr + (BUF_BITS + 1)'(pop);
    occ_nxt     = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Pending requests include this cycle's events so an idle offer reflects them at once.
  always_comb begin
    nak_eff = nak_pend || nak_set;
    ack_eff = ack_pend || accept;
    load    = (state == ACK_IDLE) && (nak_eff || ack_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_seq  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      nak_sent <= 1'b0;
      nak_pend <= 1'b0;
      ack_pend <= 1'b0;
      ack_nak  <= 1'b0;
      ack_seq  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      cfc_loc  <= 1'b1;
    end else begin
      exp_seq <= exp_seq_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      if (accept) begin
        nak_sent <= 1'b0;
      end else if (nak_set) begin
        nak_sent <= 1'b1;
      end
      // A nak carries the same ack_seq as an ack would, so it absorbs any pending ack.
      if (load) begin
        nak_pend <= 1'b0;
        ack_pend <= 1'b0;
        ack_nak  <= nak_eff;
        ack_seq  <= exp_seq_nxt;
      end else begin
        nak_pend <= nak_eff;
        ack_pend <= ack_eff;
      end
      empty   <= (occ_nxt == '0);
      full    <= (occ_nxt == BUF_LEN_P);
      cfc_loc <= (occ_nxt <= CFC_LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[BUF_BITS-1:0]] <= rx_data;
    end
  end

  always_comb begin
    pkt_vld  = !empty;
    pkt_data = mem[rd_ptr[BUF_BITS-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACK_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACK_IDLE:  if (load) state_nxt = ACK_OFFER;
      ACK_OFFER: if (ack_rdy) state_nxt = ACK_IDLE;
      default:   state_nxt = ACK_IDLE;
    endcase
  end

  always_comb begin
    ack_vld       = (state == ACK_OFFER);
    dbg_ack_state = state;
  end

endmodule
